alu: RTL and testbench
======================

# alu

Parameterised integer ALU for the datapath. It computes a result combinationally from two operands and an `alu_operation_e` opcode. It also holds a registered NZCV status-flag register that the sequencer samples for conditional branching. It sits between the register-file read ports and the writeback mux.

## Interface
- `Width`, default 8: operand and result width in bits; must be ≥ 2.
- `clk`  in  1: single clock; only the flag register uses it.
- `rst`  in  1: synchronous, active-high reset.
- `a`  in  Width: operand A; unsigned or two's complement depending on op.
- `b`  in  Width: operand B, or the shift amount for shift ops.
- `op`  in  `alu_operation_e` (4 bits): operation select.
- `result`  out  Width: combinational result.
- `flag_en`  in  1: when 1, the flag register captures this cycle's flags at the clock edge.
- `flags`  out  4: registered `{N, Z, C, V}`; bit 3 is N and bit 0 is V.
- Port declaration order is `a, b, op, result, clk, rst, flag_en, flags`, so that positional instantiation of the first four ports remains valid.

## Operation
- `alu_operation_e` is a 4-bit package enum:
  - ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOT=5, NEG=6, LSL=7, LSR=8, ASR=9.
  - Codes 10–15 are reserved and produce result 0 with all flags 0.
- ADD: a + b, truncated to Width. C = carry out. V = signed overflow (operands share a sign and the result sign differs).
- SUB: a − b, truncated. C = 1 when no borrow (a ≥ b unsigned). V = signed overflow (operand signs differ and the result sign differs from a).
- AND, OR, XOR: bitwise on a and b. C = 0, V = 0.
- NOT: ~a; b is ignored. C = 0, V = 0.
- NEG: 0 − a (two's complement of a); b is ignored.
  - C = 1 only when a = 0.
  - V = 1 only when a = most-negative (1 followed by zeros).
- Shifts take the amount s = b as an unsigned value over its full width; there is no modulo.
  - LSL: a << s with zero fill; s ≥ Width gives 0.
  - LSR: a >> s with zero fill; s ≥ Width gives 0.
  - ASR: a >>> s with sign fill; s ≥ Width gives all copies of a[Width-1].
  - s = 0 passes a through.
  - C = the last bit shifted out; C = 0 when s = 0 or s > Width.
  - V = 0.
- N = result[Width-1]. Z = (result == 0). Both are computed for every op, including reserved codes, where they evaluate to N=0, Z=1.
- Reserved codes force N, Z, C, V all to 0. This overrides the Z rule above.
- No X propagation is allowed from a valid op; every output bit is defined for every input combination.

## Timing
- `result` is purely combinational, with zero cycle latency. It is valid within the same evaluation step as a, b and op change; there are no internal registers on this path.
- `flags` is registered:
  - At posedge `clk`: if `rst`, flags ← 4'b0000.
  - Else if `flag_en`, flags ← the combinational NZCV of the current a, b, op.
  - Else flags holds.
- Reset value is `flags` = 0. `result` is unaffected by reset and keeps tracking its inputs during reset.
- `rst` takes priority over `flag_en` when both are asserted on the same edge.
- Flags reflect the operation from one cycle earlier. They are visible after the edge and stable until the next enabled edge.

## Test plan
- Width=4, no clock needed; apply each vector, wait 5 time units, check `result`:
  - (0000, 0001, ADD) → 0001
  - (0010, 0001, OR) → 0011
  - (0010, 0001, AND) → 0000
  - (0010, 0011, XOR) → 0001
  - (0010, 0011, NOT) → 1101
  - (0010, 0011, NEG) → 1110
  - (1010, 0001, ASR) → 1101
  - (1010, 0001, LSL) → 0100
- Width=4, arithmetic flags with `flag_en`=1 and one clock per vector:
  - ADD 0111+0001 → result 1000, flags {N,Z,C,V}=1001.
  - ADD 1111+0001 → result 0000, flags 0110.
  - SUB 0011−0011 → result 0000, flags 0110.
  - NEG 1000 → result 1000, flags 1001.
- Shift bounds, Width=4:
  - LSR 1010 by 0001 → 0101, C=0.
  - LSL 1010 by 0100 → 0000, C=0.
  - ASR 1010 by 1111 → 1111.
  - LSL 1001 by 0000 → 1001, C=0.
- Flag register control:
  - Load flags via an enabled ADD producing 1001.
  - Drop `flag_en` and apply SUB 0011−0011 for 3 cycles → flags stay 1001.
  - Assert `rst` together with `flag_en` → flags become 0000 on the next edge.
- Reserved op: op=4'd12 with a=1111, b=1111 → result 0000; enabled edge → flags 0000.

Source files
------------

// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu_pkg / alu
//
// Purpose:
//   Parameterised integer ALU sitting between the register-file read ports and
//   the writeback mux. The result is purely combinational. A registered NZCV
//   status register is loaded on enabled clock edges so the sequencer can
//   branch on the flags of the previous operation.
//
// Ports (in declaration order):
//   a       in  [Width-1:0]  operand A
//   b       in  [Width-1:0]  operand B, or unsigned shift amount for shifts
//   op      in  alu_operation_e (4 bits) operation select
//   result  out [Width-1:0]  combinational result
//   clk     in  1            clock, used only by the flag register
//   rst     in  1            synchronous active-high reset of the flags
//   flag_en in  1            load this cycle's NZCV into the flag register
//   flags   out [3:0]        registered {N, Z, C, V}
// -----------------------------------------------------------------------------

package alu_pkg;

  // Codes 10..15 are left unnamed and are treated as reserved by the ALU.
  typedef enum logic [3:0] {
    ADD = 4'd0,
    SUB = 4'd1,
    AND = 4'd2,
    OR  = 4'd3,
    XOR = 4'd4,
    NOT = 4'd5,
    NEG = 4'd6,
    LSL = 4'd7,
    LSR = 4'd8,
    ASR = 4'd9
  } alu_operation_e;

endpackage

module alu
  import alu_pkg::*;
#(
  parameter int Width = 8
) (
  input  logic [Width-1:0] a,
  input  logic [Width-1:0] b,
  input  alu_operation_e   op,
  output logic [Width-1:0] result,
  input  logic             clk,
  input  logic             rst,
  input  logic             flag_en,
  output logic [3:0]       flags
);

  // Width as a Width-bit value; Width < 2**Width always holds for Width >= 2.
  localparam logic [Width-1:0] WidthVal = Width'(Width);

  logic [Width:0]        sum_ext;
  logic [Width:0]        diff_ext;
  logic [Width-1:0]      neg_val;
  logic [Width:0]        lsl_ext;
  logic [Width:0]        lsr_ext;
  logic signed [Width:0] asr_ext;

  logic c_flag;
  logic v_flag;
  logic n_flag;
  logic z_flag;
  logic reserved;

  assign sum_ext  = {1'b0, a} + {1'b0, b};
  assign diff_ext = {1'b0, a} - {1'b0, b};
  assign neg_val  = '0 - a;

  // Shifts run on a vector widened by one guard bit so the last bit shifted
  // out lands in the guard position. Shift amounts larger than the vector
  // naturally push everything out, which gives the zero carry required for
  // s > Width on the logical shifts without extra compare logic.
  assign lsl_ext = {1'b0, a} << b;
  assign lsr_ext = {a, 1'b0} >> b;
  assign asr_ext = $signed({a, 1'b0}) >>> b;

  // Result and carry/overflow selection. Every path assigns defined values so
  // that no X can escape for any opcode, reserved codes included.
  always_comb begin
    result   = '0;
    c_flag   = 1'b0;
    v_flag   = 1'b0;
    reserved = 1'b0;
    case (op)
      ADD: begin
        result = sum_ext[Width-1:0];
        c_flag = sum_ext[Width];
        v_flag = (a[Width-1] == b[Width-1]) && (result[Width-1] != a[Width-1]);
      end
      SUB: begin
        result = diff_ext[Width-1:0];
        c_flag = ~diff_ext[Width];
        v_flag = (a[Width-1] != b[Width-1]) && (result[Width-1] != a[Width-1]);
      end
      AND: result = a & b;
      OR:  result = a | b;
      XOR: result = a ^ b;
      NOT: result = ~a;
      NEG: begin
        result = neg_val;
        c_flag = (a == '0);
        v_flag = (a == {1'b1, {(Width-1){1'b0}}});
      end
      LSL: begin
        result = lsl_ext[Width-1:0];
        c_flag = lsl_ext[Width];
      end
      LSR: begin
        result = lsr_ext[Width:1];
        c_flag = lsr_ext[0];
      end
      ASR: begin
        result = asr_ext[Width:1];
        // Sign fill would otherwise leak into the guard bit for s > Width.
        c_flag = (b <= WidthVal) ? asr_ext[0] : 1'b0;
      end
      default: reserved = 1'b1;
    endcase
  end

  // Reserved codes report all-zero flags, overriding the usual Z rule.
  always_comb begin
    n_flag = 1'b0;
    z_flag = 1'b0;
    if (!reserved) begin
      n_flag = result[Width-1];
      z_flag = (result == '0);
    end
  end

  // Flag register: reset wins over enable; otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags <= 4'b0000;
    end else if (flag_en) begin
      flags <= {n_flag, z_flag, c_flag, v_flag};
    end
  end

endmodule

// File: tb/tb_alu.sv
// -----------------------------------------------------------------------------
// tb_alu
//
// Purpose:
//   Self-checking bench for alu at Width=4. A behavioural model computes the
//   expected result and NZCV from plain integer arithmetic; a compare process
//   checks result and the registered flags on every falling edge. Directed
//   vectors with hand-computed literals pin the model, then randomized
//   traffic exercises all opcodes, enable and reset.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------

module tb_alu;
  import alu_pkg::*;

  localparam int W = 4;

  logic [W-1:0]   a;
  logic [W-1:0]   b;
  alu_operation_e op;
  logic [W-1:0]   result;
  logic           clk;
  logic           rst;
  logic           flag_en;
  logic [3:0]     flags;

  int checks;
  int passes;

  logic [3:0] exp_flags;
  bit         model_valid;

  alu #(.Width(W)) dut (
    .a       (a),
    .b       (b),
    .op      (op),
    .result  (result),
    .clk     (clk),
    .rst     (rst),
    .flag_en (flag_en),
    .flags   (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: returns {N, Z, C, V, result} from integer arithmetic on the
  // operand values, with signed views used for overflow detection.
  function automatic logic [7:0] ref_alu(input int ua, input int ub, input int opc);
    int  sa;
    int  sb;
    int  r;
    int  sr;
    bit  c;
    bit  v;
    bit  n;
    bit  z;
    bit  rsv;
    logic [31:0] rv;
    sa  = (ua >= 8) ? ua - 16 : ua;
    sb  = (ub >= 8) ? ub - 16 : ub;
    r   = 0;
    c   = 1'b0;
    v   = 1'b0;
    rsv = 1'b0;
    case (opc)
      0: begin r = (ua + ub) % 16; c = (ua + ub) >= 16; sr = sa + sb; v = (sr > 7) || (sr < -8); end
      1: begin r = (ua - ub + 16) % 16; c = (ua >= ub); sr = sa - sb; v = (sr > 7) || (sr < -8); end
      2: r = ua & ub;
      3: r = ua | ub;
      4: r = ua ^ ub;
      5: r = 15 - ua;
      6: begin r = (16 - ua) % 16; c = (ua == 0); v = (-sa > 7); end
      7: begin
        r = (ub >= W) ? 0 : (ua << ub) % 16;
        c = (ub >= 1 && ub <= W) ? ((ua >> (W - ub)) & 1) != 0 : 1'b0;
      end
      8: begin
        r = (ub >= W) ? 0 : (ua >> ub);
        c = (ub >= 1 && ub <= W) ? ((ua >> (ub - 1)) & 1) != 0 : 1'b0;
      end
      9: begin
        r = (ub >= W) ? ((sa < 0) ? 15 : 0) : ((sa >>> ub) & 15);
        c = (ub >= 1 && ub <= W) ? ((ua >> (ub - 1)) & 1) != 0 : 1'b0;
      end
      default: rsv = 1'b1;
    endcase
    n = (r >= 8);
    z = (r == 0);
    if (rsv) begin
      n = 1'b0;
      z = 1'b0;
    end
    rv = r;
    return {n, z, c, v, rv[3:0]};
  endfunction

  task automatic check_value(input string name, input logic [3:0] actual, input logic [3:0] expected);
    checks++;
    if (actual === expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got %b, expected %b at t=%0t", name, actual, expected, $time);
    end
  endtask

  // Drive a new vector just after a rising edge so it is stable at the next.
  task automatic apply_stimulus(input logic [3:0] va, input logic [3:0] vb, input int opc,
                                input logic fe, input logic rs);
    @(posedge clk);
    #1;
    a       = va;
    b       = vb;
    op      = alu_operation_e'(opc[3:0]);
    flag_en = fe;
    rst     = rs;
  endtask

  // Literal checks: result a little after the drive, flags after the next edge.
  task automatic check_output(input string name, input logic [3:0] exp_res);
    #3;
    check_value({name, " result"}, result, exp_res);
  endtask

  task automatic check_flags_next(input string name, input logic [3:0] exp_f);
    @(posedge clk);
    #1;
    check_value({name, " flags"}, flags, exp_f);
  endtask

  // Compare process: track the flag register at each rising edge from the
  // model, then check both outputs on the falling edge.
  always begin
    logic [7:0] m;
    @(posedge clk);
    m = ref_alu(int'(a), int'(b), int'(op));
    if (rst) begin
      exp_flags   = 4'b0000;
      model_valid = 1'b1;
    end else if (flag_en) begin
      exp_flags = m[7:4];
    end
    @(negedge clk);
    if (model_valid) begin
      m = ref_alu(int'(a), int'(b), int'(op));
      check_value("model result", result, m[3:0]);
      check_value("model flags", flags, exp_flags);
    end
  end

  initial begin
    logic [3:0] ra;
    logic [3:0] rb;
    int         ropc;
    checks      = 0;
    passes      = 0;
    model_valid = 1'b0;
    exp_flags   = 4'b0000;
    a           = '0;
    b           = '0;
    op          = ADD;
    flag_en     = 1'b0;
    rst         = 1'b1;

    apply_stimulus(4'b0000, 4'b0000, 0, 1'b0, 1'b1);
    check_flags_next("reset", 4'b0000);

    // Plain result vectors.
    apply_stimulus(4'b0000, 4'b0001, 0, 1'b0, 1'b0); check_output("add", 4'b0001);
    apply_stimulus(4'b0010, 4'b0001, 3, 1'b0, 1'b0); check_output("or", 4'b0011);
    apply_stimulus(4'b0010, 4'b0001, 2, 1'b0, 1'b0); check_output("and", 4'b0000);
    apply_stimulus(4'b0010, 4'b0011, 4, 1'b0, 1'b0); check_output("xor", 4'b0001);
    apply_stimulus(4'b0010, 4'b0011, 5, 1'b0, 1'b0); check_output("not", 4'b1101);
    apply_stimulus(4'b0010, 4'b0011, 6, 1'b0, 1'b0); check_output("neg", 4'b1110);
    apply_stimulus(4'b1010, 4'b0001, 9, 1'b0, 1'b0); check_output("asr", 4'b1101);
    apply_stimulus(4'b1010, 4'b0001, 7, 1'b0, 1'b0); check_output("lsl", 4'b0100);

    // Arithmetic flags.
    apply_stimulus(4'b0111, 4'b0001, 0, 1'b1, 1'b0); check_output("add ovf", 4'b1000);
    check_flags_next("add ovf", 4'b1001);
    apply_stimulus(4'b1111, 4'b0001, 0, 1'b1, 1'b0); check_output("add carry", 4'b0000);
    check_flags_next("add carry", 4'b0110);
    apply_stimulus(4'b0011, 4'b0011, 1, 1'b1, 1'b0); check_output("sub eq", 4'b0000);
    check_flags_next("sub eq", 4'b0110);
    apply_stimulus(4'b1000, 4'b0000, 6, 1'b1, 1'b0); check_output("neg min", 4'b1000);
    check_flags_next("neg min", 4'b1001);

    // Shift bounds; carry is flags[1].
    apply_stimulus(4'b1010, 4'b0001, 8, 1'b1, 1'b0); check_output("lsr 1", 4'b0101);
    check_flags_next("lsr 1", 4'b0000);
    apply_stimulus(4'b1010, 4'b0100, 7, 1'b1, 1'b0); check_output("lsl W", 4'b0000);
    check_flags_next("lsl W", 4'b0100);
    apply_stimulus(4'b1010, 4'b1111, 9, 1'b1, 1'b0); check_output("asr big", 4'b1111);
    check_flags_next("asr big", 4'b1000);
    apply_stimulus(4'b1001, 4'b0000, 7, 1'b1, 1'b0); check_output("lsl 0", 4'b1001);
    check_flags_next("lsl 0", 4'b1000);
    apply_stimulus(4'b0110, 4'b0011, 7, 1'b1, 1'b0); check_output("lsl 3", 4'b0000);
    check_flags_next("lsl 3", 4'b0110);

    // Flag register control: load, hold while disabled, reset beats enable.
    apply_stimulus(4'b0111, 4'b0001, 0, 1'b1, 1'b0);
    check_flags_next("load", 4'b1001);
    apply_stimulus(4'b0011, 4'b0011, 1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check_flags_next("hold", 4'b1001);
    end
    apply_stimulus(4'b0111, 4'b0001, 0, 1'b1, 1'b1);
    check_flags_next("rst prio", 4'b0000);

    // Reserved opcode.
    apply_stimulus(4'b1111, 4'b1111, 12, 1'b1, 1'b0); check_output("reserved", 4'b0000);
    check_flags_next("reserved", 4'b0000);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      ra   = 4'($urandom_range(0, 15));
      rb   = 4'($urandom_range(0, 15));
      ropc = $urandom_range(0, 15);
      apply_stimulus(ra, rb, ropc, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 31) == 0));
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
